// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: resolves GPR operands with MEM/WB forwarding, selects the
// ALU A/B sources and registers them under a valid/allowin handshake.
module ex_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_to_ex_valid,
  output logic                  ex_allowin,
  input  logic                  mem_allowin,
  input  logic                  ex_flush,
  input  logic [31:0]           id_pc,
  input  logic [REG_AW-1:0]     id_rs_idx,
  input  logic [REG_AW-1:0]     id_rt_idx,
  input  logic [DATA_WIDTH-1:0] id_rs_val,
  input  logic [DATA_WIDTH-1:0] id_rt_val,
  input  logic [15:0]           id_imm16,
  input  logic [4:0]            id_shamt,
  input  logic [3:0]            id_alu_op,
  input  logic [1:0]            id_a_sel,
  input  logic [1:0]            id_b_sel,
  input  logic [REG_AW-1:0]     id_dest,
  input  logic                  id_reg_we,
  input  logic                  id_ov_trap,
  input  logic                  mem_fwd_we,
  input  logic [REG_AW-1:0]     mem_fwd_dest,
  input  logic [DATA_WIDTH-1:0] mem_fwd_data,
  input  logic                  wb_fwd_we,
  input  logic [REG_AW-1:0]     wb_fwd_dest,
  input  logic [DATA_WIDTH-1:0] wb_fwd_data,
  output logic                  ex_valid,
  output logic                  ex_to_mem_valid,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_op,
  output logic [31:0]           ex_pc,
  output logic [REG_AW-1:0]     ex_dest,
  output logic                  ex_reg_we,
  output logic                  ex_ov_trap,
  output logic [DATA_WIDTH-1:0] ex_rt_val
);

  logic [DATA_WIDTH-1:0] rs_fwd;
  logic [DATA_WIDTH-1:0] rt_fwd;
  logic [DATA_WIDTH-1:0] a_next;
  logic [DATA_WIDTH-1:0] b_next;
  logic                  load;
  logic                  reg_we_hold;
  logic                  ov_trap_hold;

  // MEM result is younger than WB, so it wins; $0 is hard-wired to zero.
  function automatic logic [DATA_WIDTH-1:0] fwd_operand(
    input logic [REG_AW-1:0]     idx,
    input logic [DATA_WIDTH-1:0] rf_val,
    input logic                  m_we,
    input logic [REG_AW-1:0]     m_dest,
    input logic [DATA_WIDTH-1:0] m_data,
    input logic                  w_we,
    input logic [REG_AW-1:0]     w_dest,
    input logic [DATA_WIDTH-1:0] w_data
  );
    logic [DATA_WIDTH-1:0] val;
    if (idx == {REG_AW{1'b0}}) begin
      val = {DATA_WIDTH{1'b0}};
    end else if (m_we && (m_dest == idx)) begin
      val = m_data;
    end else if (w_we && (w_dest == idx)) begin
      val = w_data;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  assign ex_allowin      = !ex_valid || mem_allowin;
  assign ex_to_mem_valid = ex_valid;
  assign load            = ex_allowin && id_to_ex_valid && !ex_flush;
  assign ex_reg_we       = reg_we_hold && ex_valid;
  assign ex_ov_trap      = ov_trap_hold && ex_valid;

  // Operand resolution for rs and rt
  always_comb begin
    rs_fwd = fwd_operand(id_rs_idx, id_rs_val, mem_fwd_we, mem_fwd_dest, mem_fwd_data,
                         wb_fwd_we, wb_fwd_dest, wb_fwd_data);
    rt_fwd = fwd_operand(id_rt_idx, id_rt_val, mem_fwd_we, mem_fwd_dest, mem_fwd_data,
                         wb_fwd_we, wb_fwd_dest, wb_fwd_data);
  end

  // ALU A source select; the reserved encoding yields zero
  always_comb begin
    a_next = {DATA_WIDTH{1'b0}};
    case (id_a_sel)
      2'd0:    a_next = rs_fwd;
      2'd1:    a_next = {{(DATA_WIDTH-5){1'b0}}, id_shamt};
      2'd2:    a_next = DATA_WIDTH'(id_pc);
      2'd3:    a_next = {DATA_WIDTH{1'b0}};
      default: a_next = {DATA_WIDTH{1'b0}};
    endcase
  end

  // ALU B source select; constant 8 forms the JAL/BAL link address with A=PC
  always_comb begin
    b_next = {DATA_WIDTH{1'b0}};
    case (id_b_sel)
      2'd0:    b_next = rt_fwd;
      2'd1:    b_next = {{(DATA_WIDTH-16){id_imm16[15]}}, id_imm16};
      2'd2:    b_next = {{(DATA_WIDTH-16){1'b0}}, id_imm16};
      2'd3:    b_next = DATA_WIDTH'(4'd8);
      default: b_next = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Valid bit: flush dominates both a new load and a stall hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
    end else if (ex_flush) begin
      ex_valid <= 1'b0;
    end else if (ex_allowin) begin
      ex_valid <= id_to_ex_valid;
    end else begin
      ex_valid <= ex_valid;
    end
  end

  // Payload registers load only on an accepted instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a        <= {DATA_WIDTH{1'b0}};
      alu_b        <= {DATA_WIDTH{1'b0}};
      alu_op       <= 4'd0;
      ex_pc        <= 32'd0;
      ex_dest      <= {REG_AW{1'b0}};
      reg_we_hold  <= 1'b0;
      ov_trap_hold <= 1'b0;
      ex_rt_val    <= {DATA_WIDTH{1'b0}};
    end else if (load) begin
      alu_a        <= a_next;
      alu_b        <= b_next;
      alu_op       <= id_alu_op;
      ex_pc        <= id_pc;
      ex_dest      <= id_dest;
      reg_we_hold  <= id_reg_we;
      ov_trap_hold <= id_ov_trap;
      ex_rt_val    <= rt_fwd;
    end else begin
      alu_a        <= alu_a;
      alu_b        <= alu_b;
      alu_op       <= alu_op;
      ex_pc        <= ex_pc;
      ex_dest      <= ex_dest;
      reg_we_hold  <= reg_we_hold;
      ov_trap_hold <= ov_trap_hold;
      ex_rt_val    <= ex_rt_val;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus random
// traffic compared against a transaction-level model of the stage.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_to_ex_valid, mem_allowin, ex_flush;
  logic        ex_allowin, ex_valid, ex_to_mem_valid, ex_reg_we, ex_ov_trap;
  logic [31:0] id_pc, id_rs_val, id_rt_val, mem_fwd_data, wb_fwd_data;
  logic [4:0]  id_rs_idx, id_rt_idx, id_shamt, id_dest, mem_fwd_dest, wb_fwd_dest;
  logic [15:0] id_imm16;
  logic [3:0]  id_alu_op, alu_op;
  logic [1:0]  id_a_sel, id_b_sel;
  logic        id_reg_we, id_ov_trap, mem_fwd_we, wb_fwd_we;
  logic [31:0] alu_a, alu_b, ex_pc, ex_rt_val;
  logic [4:0]  ex_dest;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: what the EX stage should hold
  logic        m_valid, m_we, m_ov;
  logic [31:0] m_a, m_b, m_pc, m_rt;
  logic [3:0]  m_op;
  logic [4:0]  m_dest;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_to_ex_valid(id_to_ex_valid), .ex_allowin(ex_allowin),
    .mem_allowin(mem_allowin), .ex_flush(ex_flush), .id_pc(id_pc),
    .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx), .id_rs_val(id_rs_val),
    .id_rt_val(id_rt_val), .id_imm16(id_imm16), .id_shamt(id_shamt),
    .id_alu_op(id_alu_op), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_dest(id_dest), .id_reg_we(id_reg_we), .id_ov_trap(id_ov_trap),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_dest(mem_fwd_dest), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_dest(wb_fwd_dest), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_to_mem_valid(ex_to_mem_valid), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .ex_pc(ex_pc), .ex_dest(ex_dest),
    .ex_reg_we(ex_reg_we), .ex_ov_trap(ex_ov_trap), .ex_rt_val(ex_rt_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // value of a GPR as seen by the instruction in ID, newest producer first
  function automatic logic [31:0] gpr(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (mem_fwd_we && mem_fwd_dest == idx) return mem_fwd_data;
    if (wb_fwd_we && wb_fwd_dest == idx) return wb_fwd_data;
    return rf;
  endfunction

  function automatic logic [31:0] src_a();
    case (id_a_sel)
      2'd0:    return gpr(id_rs_idx, id_rs_val);
      2'd1:    return 32'(id_shamt);
      2'd2:    return id_pc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] src_b();
    case (id_b_sel)
      2'd0:    return gpr(id_rt_idx, id_rt_val);
      2'd1:    return 32'($signed(id_imm16));
      2'd2:    return 32'(id_imm16);
      default: return 32'd8;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_we = 1'b0; m_ov = 1'b0; m_a = 32'd0; m_b = 32'd0;
    m_pc = 32'd0; m_rt = 32'd0; m_op = 4'd0; m_dest = 5'd0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_valid"}, 32'(ex_valid), 32'(m_valid));
    check({pfx, "_to_mem"}, 32'(ex_to_mem_valid), 32'(m_valid));
    check({pfx, "_a"}, alu_a, m_a);
    check({pfx, "_b"}, alu_b, m_b);
    check({pfx, "_op"}, 32'(alu_op), 32'(m_op));
    check({pfx, "_pc"}, ex_pc, m_pc);
    check({pfx, "_dest"}, 32'(ex_dest), 32'(m_dest));
    check({pfx, "_we"}, 32'(ex_reg_we), 32'(m_valid & m_we));
    check({pfx, "_ov"}, 32'(ex_ov_trap), 32'(m_valid & m_ov));
    check({pfx, "_rt"}, ex_rt_val, m_rt);
  endtask

  task automatic clear_inputs();
    id_to_ex_valid = 1'b0; mem_allowin = 1'b1; ex_flush = 1'b0; id_pc = 32'd0;
    id_rs_idx = 5'd0; id_rt_idx = 5'd0; id_rs_val = 32'd0; id_rt_val = 32'd0;
    id_imm16 = 16'd0; id_shamt = 5'd0; id_alu_op = 4'd0; id_a_sel = 2'd0;
    id_b_sel = 2'd0; id_dest = 5'd0; id_reg_we = 1'b0; id_ov_trap = 1'b0;
    mem_fwd_we = 1'b0; mem_fwd_dest = 5'd0; mem_fwd_data = 32'd0;
    wb_fwd_we = 1'b0; wb_fwd_dest = 5'd0; wb_fwd_data = 32'd0;
  endtask

  task automatic randomize_inputs();
    id_to_ex_valid = ($urandom_range(0, 3) != 0);
    mem_allowin    = ($urandom_range(0, 3) != 0);
    ex_flush       = ($urandom_range(0, 9) == 0);
    id_pc = $urandom; id_rs_idx = 5'($urandom_range(0, 7)); id_rt_idx = 5'($urandom_range(0, 7));
    id_rs_val = $urandom; id_rt_val = $urandom; id_imm16 = 16'($urandom);
    id_shamt = 5'($urandom); id_alu_op = 4'($urandom_range(0, 12));
    id_a_sel = 2'($urandom); id_b_sel = 2'($urandom); id_dest = 5'($urandom);
    id_reg_we = 1'($urandom); id_ov_trap = 1'($urandom);
    mem_fwd_we = 1'($urandom); mem_fwd_dest = 5'($urandom_range(0, 7)); mem_fwd_data = $urandom;
    wb_fwd_we = 1'($urandom); wb_fwd_dest = 5'($urandom_range(0, 7)); wb_fwd_data = $urandom;
  endtask

  // inputs are set at a falling edge; run one clock and check the result
  task automatic cycle(input string pfx);
    logic nv, accept;
    logic [31:0] na, nb, nrt;
    #1;
    check({pfx, "_allowin"}, 32'(ex_allowin), 32'(!m_valid || mem_allowin));
    accept = !ex_flush && (!m_valid || mem_allowin) && id_to_ex_valid;
    nv = ex_flush ? 1'b0 : ((!m_valid || mem_allowin) ? id_to_ex_valid : m_valid);
    na = src_a(); nb = src_b(); nrt = gpr(id_rt_idx, id_rt_val);
    @(posedge clk);
    m_valid = nv;
    if (accept) begin
      m_a = na; m_b = nb; m_rt = nrt; m_op = id_alu_op; m_pc = id_pc;
      m_dest = id_dest; m_we = id_reg_we; m_ov = id_ov_trap;
    end
    @(negedge clk);
    check_outputs(pfx);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ADDI $3=5 + 0xFFFF sign-extended, overflow-trapping
    id_to_ex_valid = 1'b1; id_rs_idx = 5'd3; id_rs_val = 32'd5; id_imm16 = 16'hFFFF;
    id_b_sel = 2'd1; id_alu_op = 4'd2; id_ov_trap = 1'b1; id_reg_we = 1'b1; id_dest = 5'd7;
    cycle("addi");
    check("addi_a_abs", alu_a, 32'd5);
    check("addi_b_abs", alu_b, 32'hFFFF_FFFF);
    check("addi_ov_abs", 32'(ex_ov_trap), 32'd1);

    // forwarding priority and $0
    clear_inputs();
    id_to_ex_valid = 1'b1; id_rs_idx = 5'd4; id_rs_val = 32'h11;
    mem_fwd_we = 1'b1; mem_fwd_dest = 5'd4; mem_fwd_data = 32'hAA;
    wb_fwd_we = 1'b1; wb_fwd_dest = 5'd4; wb_fwd_data = 32'hBB;
    cycle("fwd_mem");
    check("fwd_mem_abs", alu_a, 32'hAA);
    mem_fwd_we = 1'b0;
    cycle("fwd_wb");
    check("fwd_wb_abs", alu_a, 32'hBB);
    id_rs_idx = 5'd0; mem_fwd_we = 1'b1; mem_fwd_dest = 5'd0; mem_fwd_data = 32'h55;
    cycle("fwd_zero");
    check("fwd_zero_abs", alu_a, 32'd0);

    // stall: EX holds while ID keeps changing
    id_rs_idx = 5'd2; id_rs_val = 32'hCAFE; mem_fwd_we = 1'b0;
    cycle("pre_stall");
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      id_to_ex_valid = 1'b1; mem_allowin = 1'b0; ex_flush = 1'b0;
      cycle("stall");
      check("stall_a_abs", alu_a, 32'hCAFE);
      check("stall_allowin", 32'(ex_allowin), 32'd0);
    end

    // flush collides with an incoming instruction
    clear_inputs();
    id_to_ex_valid = 1'b1; id_reg_we = 1'b1; ex_flush = 1'b1;
    cycle("flush");
    check("flush_valid_abs", 32'(ex_valid), 32'd0);
    check("flush_we_abs", 32'(ex_reg_we), 32'd0);

    // SLL shamt=31 on rt=1, then LUI 0x1234
    clear_inputs();
    id_to_ex_valid = 1'b1; id_a_sel = 2'd1; id_shamt = 5'd31;
    id_rt_idx = 5'd5; id_rt_val = 32'd1;
    cycle("sll");
    check("sll_a_abs", alu_a, 32'd31);
    check("sll_b_abs", alu_b, 32'd1);
    clear_inputs();
    id_to_ex_valid = 1'b1; id_b_sel = 2'd2; id_imm16 = 16'h1234;
    cycle("lui");
    check("lui_b_abs", alu_b, 32'h0000_1234);

    // link: PC + 8
    id_a_sel = 2'd2; id_b_sel = 2'd3; id_pc = 32'h0040_0100;
    cycle("link");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      cycle("rand");
    end

    // asynchronous reset with a live instruction in EX
    clear_inputs();
    id_to_ex_valid = 1'b1; id_rs_idx = 5'd6; id_rs_val = 32'h1234_5678;
    id_b_sel = 2'd3; id_alu_op = 4'd5;
    cycle("pre_rst");
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_a", alu_a, 32'd0);
    check("rst_b", alu_b, 32'd0);
    check("rst_op", 32'(alu_op), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_outputs("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
